// File: rtl/sevenseg_pkg.sv
// Shared glyph table and decode helper for the multiplexed
// seven-segment driver.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] nibble,
    input logic       hex_mode
  );
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: s = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: s = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: s = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: s = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: s = hex_mode ? SEG_F : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational nibble-to-glyph decoder with a forced-blank
// override used for leading-zero suppression.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg_n
);

  assign seg_n = blank ? SEG_BLANK
                       : seg_decode(nibble, hex_mode);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-division scanner for NUM_DIGITS common-anode digits
// with shadowed data, blank gap and leading-zero blanking.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    hex_mode_i,
  input  logic                    lzb_en_i,
  input  logic                    load_i,
  output logic [6:0]              seg_n_o,
  output logic                    dp_n_o,
  output logic [NUM_DIGITS-1:0]   an_n_o,
  output logic                    frame_o
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GAP_END =
    CW'(BLANK_CYCLES);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;

  logic                    wrap;
  logic                    gap;
  logic                    on;
  logic                    lz_blank;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    zrun;
  logic [6:0]              seg_d;

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      dp_q  <= '0;
      en_q  <= '0;
    end else if (load_i) begin
      dig_q <= digits_i;
      dp_q  <= dp_i;
      en_q  <= digit_en_i;
    end
  end

  // lead_zero[i]: every nibble from the top down to i is zero
  always_comb begin
    lead_zero = '0;
    zrun      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun         = zrun & (dig_q[4*i +: 4] == 4'h0);
      lead_zero[i] = zrun;
    end
  end

  always_comb begin
    nib      = dig_q[4*idx +: 4];
    gap      = (BLANK_CYCLES != 0) && (cnt < GAP_END);
    on       = !gap && en_q[idx];
    lz_blank = lzb_en_i && lead_zero[idx]
               && (idx != '0);
  end

  sevenseg_decode u_dec (
    .nibble   (nib),
    .hex_mode (hex_mode_i),
    .blank    (lz_blank),
    .seg_n    (seg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_o  <= '1;
      seg_n_o <= SEG_BLANK;
      dp_n_o  <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      an_n_o  <= on ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg_n_o <= seg_d;
      dp_n_o  <= ~(on && dp_q[idx]);
      frame_o <= wrap && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench: per-slot expectations are queued at frame
// boundaries and checked by a monitor at each digit turn-on.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic        hex_mode_i = 1'b0;
  logic        lzb_en_i = 1'b0;
  logic        load_i = 1'b0;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;
  logic [3:0]  an_n_o;
  logic        frame_o;

  sevenseg_scan #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .digit_en_i (digit_en_i),
    .hex_mode_i (hex_mode_i),
    .lzb_en_i   (lzb_en_i),
    .load_i     (load_i),
    .seg_n_o    (seg_n_o),
    .dp_n_o     (dp_n_o),
    .an_n_o     (an_n_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [3:0] prev_an = 4'hF;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] an,
                      input logic [6:0] seg,
                      input logic dp);
    exp_t x;
    x.an = an; x.seg = seg; x.dp = dp;
    q.push_back(x);
  endtask

  // monitor: a digit turning on is one presented slot
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_an = 4'hF;
    end else begin
      if (an_n_o != 4'hF && prev_an == 4'hF
          && q.size() > 0) begin
        e = q.pop_front();
        chk("slot_an", 32'(an_n_o), 32'(e.an));
        chk("slot_seg", 32'(seg_n_o), 32'(e.seg));
        chk("slot_dp", 32'(dp_n_o), 32'(e.dp));
      end
      prev_an = an_n_o;
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 200);
    if (!frame_o) chk("frame_timeout", 0, 1);
  endtask

  task automatic apply(input logic [15:0] d,
                       input logic [3:0] dp,
                       input logic [3:0] en,
                       input logic hx,
                       input logic lz);
    @(negedge clk);
    digits_i = d; dp_i = dp; digit_en_i = en;
    hex_mode_i = hx; lzb_en_i = lz; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    wait_frame();
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_an"}, 32'(an_n_o), 32'hF);
    chk({nm, "_seg"}, 32'(seg_n_o), 32'h7F);
    chk({nm, "_dp"}, 32'(dp_n_o), 32'h1);
    chk({nm, "_frame"}, 32'(frame_o), 32'h0);
  endtask

  task automatic startup();
    digits_i = 16'h1234; dp_i = 4'b0100;
    digit_en_i = 4'hF; hex_mode_i = 1'b0;
    lzb_en_i = 1'b0; load_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    chk("st_c1_an", 32'(an_n_o), 32'hF);
    @(posedge clk); #1;
    chk("st_c2_an", 32'(an_n_o), 32'hF);
    @(posedge clk); #1;
    chk("st_c3_an", 32'(an_n_o), 32'hE);
    chk("st_c3_seg", 32'(seg_n_o), 32'h19);
    chk("st_c3_dp", 32'(dp_n_o), 32'h1);
  endtask

  initial begin
    int t0;
    int seen;
    repeat (3) @(negedge clk);
    check_idle("rst");
    startup();

    // 1234, dp on digit 2
    apply(16'h1234, 4'b0100, 4'hF, 1'b0, 1'b0);
    push(4'hE, 7'h19, 1'b1);
    push(4'hD, 7'h30, 1'b1);
    push(4'hB, 7'h24, 1'b0);
    push(4'h7, 7'h79, 1'b1);
    t0 = cyc;
    wait_frame();
    chk("frame_period", 32'(cyc - t0), 32);
    chk("drain_1234", 32'(q.size()), 0);

    // load lands on the idx0->idx1 wrap edge
    digits_i = 16'h5678; dp_i = 4'b0000;
    push(4'hE, 7'h19, 1'b1);
    push(4'hD, 7'h78, 1'b1);
    push(4'hB, 7'h02, 1'b1);
    push(4'h7, 7'h12, 1'b1);
    repeat (7) @(posedge clk);
    #1 load_i = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    wait_frame();
    chk("drain_wrapload", 32'(q.size()), 0);

    apply(16'h00A0, 4'b0000, 4'hF, 1'b1, 1'b1);
    push(4'hE, 7'h40, 1'b1);
    push(4'hD, 7'h08, 1'b1);
    push(4'hB, 7'h7F, 1'b1);
    push(4'h7, 7'h7F, 1'b1);
    wait_frame();
    chk("drain_a0_hex", 32'(q.size()), 0);

    apply(16'h00A0, 4'b0000, 4'hF, 1'b0, 1'b1);
    push(4'hE, 7'h40, 1'b1);
    push(4'hD, 7'h7F, 1'b1);
    push(4'hB, 7'h7F, 1'b1);
    push(4'h7, 7'h7F, 1'b1);
    wait_frame();
    chk("drain_a0_dec", 32'(q.size()), 0);

    apply(16'h0000, 4'b0000, 4'hF, 1'b0, 1'b1);
    push(4'hE, 7'h40, 1'b1);
    push(4'hD, 7'h7F, 1'b1);
    push(4'hB, 7'h7F, 1'b1);
    push(4'h7, 7'h7F, 1'b1);
    wait_frame();
    chk("drain_zero", 32'(q.size()), 0);

    // digit 0 disabled: its slot stays dark, dp too
    apply(16'h0000, 4'b0001, 4'b1110, 1'b0, 1'b1);
    push(4'hD, 7'h7F, 1'b1);
    push(4'hB, 7'h7F, 1'b1);
    push(4'h7, 7'h7F, 1'b1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (an_n_o != 4'hF || dp_n_o != 1'b1) seen++;
    end
    chk("dis_dark", 32'(seen), 0);
    wait_frame();
    chk("drain_dis", 32'(q.size()), 0);

    // async reset in the middle of the idx=2 slot
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_an", 32'(an_n_o), 32'hB);
    #1 rst_n = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(negedge clk);
    check_idle("midrst_hold");
    startup();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
